// File: rtl/fetch_seq_if.sv
// fetch_seq_if: memory bus and status bundle between the fetch sequencer
// (master) and its memory/step source/observer (slave).
interface fetch_seq_if;
  logic        Step;
  logic [15:0] Dout;
  logic [15:0] StData;
  logic [5:0]  Adrs;
  logic [15:0] Din;
  logic        WrtMem;
  logic        MemStep;
  logic [5:0]  PC;
  logic [15:0] IR;
  logic [15:0] LdData;
  logic        Halted;

  modport master (
    input  Step, Dout, StData,
    output Adrs, Din, WrtMem, MemStep, PC, IR, LdData, Halted
  );

  modport slave (
    output Step, Dout, StData,
    input  Adrs, Din, WrtMem, MemStep, PC, IR, LdData, Halted
  );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: four-state instruction sequencer (FETCH, DECODE, MEM, HALT)
// driving a 64x16 combinational-read memory.
// Instruction word: [15:14] opcode (00 NOP, 01 LD, 10 ST, 11 JMP/HALT),
// [13] selects HALT when opcode is 11, [5:0] memory/jump address.
// Build option: define SINGLE_STEP_EN to advance only on Step pulses;
// without it the machine advances every clock and Step is ignored.
module fetch_seq #(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input logic         clk,
  input logic         reset,
  fetch_seq_if.master bus
);

  typedef enum logic [1:0] {FETCH, DECODE, MEM, HALT} state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;

  state_t      state, state_next;
  logic [5:0]  pc, pc_next;
  logic [15:0] ir, ir_next;
  logic [15:0] ld_data, ld_data_next;
  logic [5:0]  adrs;
  logic        wrt_mem;
  logic        adv;

`ifdef SINGLE_STEP_EN
  assign adv = bus.Step;
`else
  logic unused_step;
  assign adv         = 1'b1;
  assign unused_step = bus.Step;
`endif

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      ld_data <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_next;
      pc      <= pc_next;
      ir      <= ir_next;
      ld_data <= ld_data_next;
    end
  end

  // Next-state, datapath updates and memory controls; all moves gated by adv.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_next   = state;
    pc_next      = pc;
    ir_next      = ir;
    ld_data_next = ld_data;
    adrs         = pc;
    wrt_mem      = 1'b0;

    case (state)
      FETCH: begin
        if (adv) begin
          ir_next    = bus.Dout;
          pc_next    = pc + 6'd1;  // 6-bit add wraps 63 -> 0
          state_next = DECODE;
        end
      end

      DECODE: begin
        if (adv) begin
          case (ir[15:14])
            OP_NOP:       state_next = FETCH;
            OP_LD, OP_ST: state_next = MEM;
            default: begin
              if (ir[13]) begin
                state_next = HALT;
              end else begin
                pc_next    = ir[5:0];
                state_next = FETCH;
              end
            end
          endcase
        end
      end

      MEM: begin
        adrs    = ir[5:0];
        // Write enable stays up for the whole state; the memory commits only
        // on the clock where its Step (MemStep) is also high.
        wrt_mem = (ir[15:14] == OP_ST);
        if (adv) begin
          if (ir[15:14] == OP_LD) begin
            ld_data_next = bus.Dout;
          end
          state_next = FETCH;
        end
      end

      HALT: begin
        // Absorbing: only reset leaves this state.
      end

      default: state_next = FETCH;
    endcase
  end

  assign bus.Adrs    = adrs;
  assign bus.WrtMem  = wrt_mem;
  assign bus.Din     = bus.StData;
  assign bus.MemStep = adv;
  assign bus.PC      = pc;
  assign bus.IR      = ir;
  assign bus.LdData  = ld_data;
  assign bus.Halted  = (state == HALT);

endmodule
